// File: rtl/phys_free_list_pkg.sv
// Shared sizing and types for the physical register file.
// Rename and the free list both import this package.
package phys_free_list_pkg;

    localparam int PROJ_NUM_PHYS_REGS = 64;
    localparam int PROJ_NUM_ARCH_REGS = 32;
    localparam int PROJ_LOG_PHYS      = $clog2(PROJ_NUM_PHYS_REGS);

    // Physical register number.
    typedef logic [PROJ_LOG_PHYS-1:0] phys_reg_t;

    // Free-entry count; one extra bit so a completely full list (NUM_PHYS) is representable.
    typedef logic [PROJ_LOG_PHYS:0] free_cnt_t;

endpackage : phys_free_list_pkg

// File: rtl/phys_free_list_if.sv
// Rename/retire <-> free list signal bundle.
// The master modport belongs to rename/retire, which drives the requests.
// The slave modport belongs to the free list, which returns registered status.
interface phys_free_list_if
    import phys_free_list_pkg::*;
#(
    parameter int LOG_PHYS = PROJ_LOG_PHYS
);
    logic                Grabbed_regs;
    logic                Release_valid;
    logic [LOG_PHYS-1:0] Release_reg;
    logic                Commit_alloc;
    logic                Flush;
    logic [LOG_PHYS-1:0] Free_phys_reg;
    logic                Free_reg_avail;
    logic [LOG_PHYS:0]   Free_count;
    logic                Overflow_err;
    logic                Underflow_err;
    logic                Dup_release_err;

    modport master (
        output Grabbed_regs, Release_valid, Release_reg, Commit_alloc, Flush,
        input  Free_phys_reg, Free_reg_avail, Free_count,
               Overflow_err, Underflow_err, Dup_release_err
    );

    modport slave (
        input  Grabbed_regs, Release_valid, Release_reg, Commit_alloc, Flush,
        output Free_phys_reg, Free_reg_avail, Free_count,
               Overflow_err, Underflow_err, Dup_release_err
    );
endinterface : phys_free_list_if

// File: rtl/free_list_ring.sv
// Circular storage for the free list. It has one tail write port and one
// asynchronous read port, and is preloaded at reset with a run of consecutive
// register numbers.
// With FREELIST_DUPCHECK_EN defined, every entry is also exported so that the
// flush path can rebuild the free vector.
module free_list_ring #(
    parameter int DEPTH      = 64,
    parameter int WIDTH      = 6,
    parameter int INIT_BASE  = 32,
    parameter int INIT_COUNT = 32,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
`ifdef FREELIST_DUPCHECK_EN
   ,output logic [WIDTH-1:0] entries_o [DEPTH]
`endif
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Ring storage: preload the initial free run at reset, then write at the tail.
    // NOTE: this memory is reset on purpose. The first INIT_COUNT entries are the
    // architectural free list, and the remaining entries get a defined value.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= (i < INIT_COUNT) ? WIDTH'(INIT_BASE + i) : '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

`ifdef FREELIST_DUPCHECK_EN
    assign entries_o = mem_q;
`endif

endmodule : free_list_ring

// File: rtl/phys_free_list.sv
// Physical-register free list that feeds rename.
// There is a speculative head for allocation and a commit head for flush
// recovery. Retire returns registers at the tail.
// Optional macro FREELIST_DUPCHECK_EN adds free-vector tracking and drops
// duplicate releases.
module phys_free_list
    import phys_free_list_pkg::*;
#(
    parameter int NUM_PHYS = PROJ_NUM_PHYS_REGS,
    parameter int NUM_ARCH = PROJ_NUM_ARCH_REGS,
    parameter int LOG_PHYS = PROJ_LOG_PHYS
) (
    input  logic              CLK,
    input  logic              RESET,
    phys_free_list_if.slave   fl
);

    localparam logic [LOG_PHYS:0]   CNT_FULL  = (LOG_PHYS+1)'(NUM_PHYS);
    localparam logic [LOG_PHYS:0]   CNT_RESET = (LOG_PHYS+1)'(NUM_PHYS - NUM_ARCH);
    localparam logic [LOG_PHYS-1:0] TAIL_RST  = LOG_PHYS'(NUM_PHYS - NUM_ARCH);

    logic [LOG_PHYS-1:0] head_q, head_d;
    logic [LOG_PHYS-1:0] commit_head_q, commit_head_d;
    logic [LOG_PHYS-1:0] tail_q, tail_d;
    logic [LOG_PHYS:0]   spec_count_q, spec_count_d;
    logic [LOG_PHYS:0]   commit_count_q, commit_count_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    logic [LOG_PHYS-1:0] head_reg;

    logic list_empty, list_full;
    logic grab_req, grab_ok;
    logic rel_req, rel_ok, rel_dup;

`ifdef FREELIST_DUPCHECK_EN
    logic [LOG_PHYS-1:0] ring_entries [NUM_PHYS];
`endif

    free_list_ring #(
        .DEPTH      (NUM_PHYS),
        .WIDTH      (LOG_PHYS),
        .INIT_BASE  (NUM_ARCH),
        .INIT_COUNT (NUM_PHYS - NUM_ARCH)
    ) u_ring (
        .CLK       (CLK),
        .RESET     (RESET),
        .wr_en_i   (rel_ok),
        .wr_addr_i (tail_q),
        .wr_data_i (fl.Release_reg),
        .rd_addr_i (head_q),
        .rd_data_o (head_reg)
`ifdef FREELIST_DUPCHECK_EN
       ,.entries_o (ring_entries)
`endif
    );

    // Accept/reject decisions. These are based only on registered counts, so
    // a release into an empty list cannot satisfy a grab in the same cycle.
    assign list_empty = (spec_count_q == '0);
    assign list_full  = (commit_count_q == CNT_FULL);
    assign grab_req   = fl.Grabbed_regs && !fl.Flush;
    assign grab_ok    = grab_req && !list_empty;
    assign rel_req    = fl.Release_valid && (fl.Release_reg != '0);
    assign rel_ok     = rel_req && !list_full && !rel_dup;

    // Pointer and count next state; a flush rewinds to the post-commit state of this cycle.
    // NOTE: every variable gets a default at the top, so no path leaves one unassigned (no latch).
    always_comb begin
        commit_head_d  = commit_head_q + LOG_PHYS'(fl.Commit_alloc);
        commit_count_d = commit_count_q + (LOG_PHYS+1)'(rel_ok)
                                        - (LOG_PHYS+1)'(fl.Commit_alloc);
        tail_d         = tail_q + LOG_PHYS'(rel_ok);
        head_d         = head_q + LOG_PHYS'(grab_ok);
        spec_count_d   = spec_count_q + (LOG_PHYS+1)'(rel_ok) - (LOG_PHYS+1)'(grab_ok);
        overflow_d     = overflow_q  | (rel_req && list_full);
        underflow_d    = underflow_q | (grab_req && list_empty);
        if (fl.Flush) begin
            head_d       = commit_head_d;
            spec_count_d = commit_count_d;
        end
    end

    // Pointer, count and sticky-error state.
    // NOTE: sequential state uses non-blocking assignment, so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            head_q         <= '0;
            commit_head_q  <= '0;
            tail_q         <= TAIL_RST;
            spec_count_q   <= CNT_RESET;
            commit_count_q <= CNT_RESET;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            head_q         <= head_d;
            commit_head_q  <= commit_head_d;
            tail_q         <= tail_d;
            spec_count_q   <= spec_count_d;
            commit_count_q <= commit_count_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

`ifdef FREELIST_DUPCHECK_EN
    logic [NUM_PHYS-1:0] free_vec_q, free_vec_d, skip_mask;
    logic                dup_q, dup_d;

    assign rel_dup = free_vec_q[fl.Release_reg];

    // On a flush, mark as free every register that sits in the rewound window [commit_head_d, head_q).
    always_comb begin
        logic [LOG_PHYS-1:0] skip_len;
        skip_mask = '0;
        skip_len  = head_q - commit_head_d;
        for (int i = 0; i < NUM_PHYS; i++) begin
            logic [LOG_PHYS-1:0] off;
            off = LOG_PHYS'(i) - commit_head_d;
            if (off < skip_len) begin
                skip_mask[ring_entries[i]] = 1'b1;
            end
        end
    end

    // Free-vector update: a grab clears a bit, a release sets one, and a flush restores the skipped registers.
    always_comb begin
        free_vec_d = free_vec_q;
        if (fl.Flush) begin
            free_vec_d = free_vec_q | skip_mask;
        end else if (grab_ok) begin
            free_vec_d[head_reg] = 1'b0;
        end
        if (rel_ok) begin
            free_vec_d[fl.Release_reg] = 1'b1;
        end
        dup_d = dup_q | (rel_req && rel_dup);
    end

    // Free vector and duplicate-release flag.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NUM_PHYS; i++) begin
                free_vec_q[i] <= (i >= NUM_ARCH);
            end
            dup_q <= 1'b0;
        end else begin
            free_vec_q <= free_vec_d;
            dup_q      <= dup_d;
        end
    end

    assign fl.Dup_release_err = dup_q;
`else
    assign rel_dup            = 1'b0;
    assign fl.Dup_release_err = 1'b0;
`endif

    assign fl.Free_phys_reg  = head_reg;
    assign fl.Free_reg_avail = !list_empty;
    assign fl.Free_count     = spec_count_q;
    assign fl.Overflow_err   = overflow_q;
    assign fl.Underflow_err  = underflow_q;

endmodule : phys_free_list

// File: tb/tb_phys_free_list.sv
// Directed bench for phys_free_list. It covers the reset image, draining,
// underflow, release, flush rewind, overflow, pointer wrap and the optional
// duplicate check.
module tb_phys_free_list;
    import phys_free_list_pkg::*;

    logic CLK = 1'b0;
    logic RESET;
    int   total = 0;
    int   bad   = 0;

    always #5 CLK = ~CLK;

    phys_free_list_if fl_if ();

    phys_free_list dut (
        .CLK   (CLK),
        .RESET (RESET),
        .fl    (fl_if.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        fl_if.Grabbed_regs  = 1'b0;
        fl_if.Release_valid = 1'b0;
        fl_if.Release_reg   = '0;
        fl_if.Commit_alloc  = 1'b0;
        fl_if.Flush         = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
    endtask

    // Watchdog: the sequence below is fixed-length, so this should never fire.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        RESET = 1'b1;
        #12;
        check("rst_reg",   32'(fl_if.Free_phys_reg),   32);
        check("rst_avail", 32'(fl_if.Free_reg_avail),  1);
        check("rst_count", 32'(fl_if.Free_count),      32);
        check("rst_ovf",   32'(fl_if.Overflow_err),    0);
        check("rst_unf",   32'(fl_if.Underflow_err),   0);
        check("rst_dup",   32'(fl_if.Dup_release_err), 0);
        tick();
        RESET = 1'b0;

        // Drain all 32 free registers.
        fl_if.Grabbed_regs = 1'b1;
        for (int i = 0; i < 32; i++) begin
            check("drain_reg", 32'(fl_if.Free_phys_reg), 32'(32 + i));
            tick();
        end
        check("empty_avail", 32'(fl_if.Free_reg_avail), 0);
        check("empty_count", 32'(fl_if.Free_count),     0);
        check("empty_unf",   32'(fl_if.Underflow_err),  0);

        // A 33rd grab sets underflow and leaves the head unchanged (ring[32] is still the reset 0).
        tick();
        check("unf_set",   32'(fl_if.Underflow_err), 1);
        check("unf_count", 32'(fl_if.Free_count),    0);
        check("unf_head",  32'(fl_if.Free_phys_reg), 0);

        // A release into the empty list does not satisfy the same-cycle grab.
        fl_if.Release_valid = 1'b1;
        fl_if.Release_reg   = 6'd63;
        tick();
        fl_if.Grabbed_regs = 1'b0;
        check("rel_empty_avail", 32'(fl_if.Free_reg_avail), 1);
        check("rel_empty_reg",   32'(fl_if.Free_phys_reg),  63);
        check("rel_empty_count", 32'(fl_if.Free_count),     1);

        // Releasing reg 0 is ignored and sets no error.
        fl_if.Release_reg = 6'd0;
        tick();
        check("rel0_count", 32'(fl_if.Free_count),   1);
        check("rel0_ovf",   32'(fl_if.Overflow_err), 0);
        fl_if.Release_reg = 6'd50;
        tick();
        fl_if.Release_valid = 1'b0;
        check("rel50_count", 32'(fl_if.Free_count), 2);
        fl_if.Grabbed_regs = 1'b1;
        tick();
        fl_if.Grabbed_regs = 1'b0;
        check("rel0_tail_hold", 32'(fl_if.Free_phys_reg), 50);
        check("grab50_count",   32'(fl_if.Free_count),    1);

        // Assert reset in the middle of a cycle: state must be discarded immediately.
        fl_if.Grabbed_regs = 1'b1;
        tick();
        #2;
        RESET = 1'b1;
        #1;
        check("async_rst_count", 32'(fl_if.Free_count),    32);
        check("async_rst_reg",   32'(fl_if.Free_phys_reg), 32);
        check("async_rst_unf",   32'(fl_if.Underflow_err), 0);
        idle();
        tick();
        RESET = 1'b0;

        // Grab 32..36, commit two allocations, then flush back to commit_head=2.
        fl_if.Grabbed_regs = 1'b1;
        repeat (5) tick();
        fl_if.Grabbed_regs = 1'b0;
        check("grab5_reg",   32'(fl_if.Free_phys_reg), 37);
        check("grab5_count", 32'(fl_if.Free_count),    27);
        fl_if.Commit_alloc = 1'b1;
        repeat (2) tick();
        fl_if.Commit_alloc = 1'b0;
        check("commit_spec", 32'(fl_if.Free_count), 27);
        fl_if.Flush        = 1'b1;
        fl_if.Grabbed_regs = 1'b1;
        tick();
        idle();
        check("flush_reg",   32'(fl_if.Free_phys_reg), 34);
        check("flush_count", 32'(fl_if.Free_count),    30);
        check("flush_unf",   32'(fl_if.Underflow_err), 0);

        // A flush with a same-cycle commit_alloc rewinds to the advanced commit head.
        fl_if.Grabbed_regs = 1'b1;
        repeat (3) tick();
        fl_if.Grabbed_regs = 1'b0;
        check("regrab_reg", 32'(fl_if.Free_phys_reg), 37);
        fl_if.Flush        = 1'b1;
        fl_if.Commit_alloc = 1'b1;
        tick();
        idle();
        check("flush_ca_reg",   32'(fl_if.Free_phys_reg), 35);
        check("flush_ca_count", 32'(fl_if.Free_count),    29);

        // Overflow: fill commit_count to 64, then release one more.
        do_reset();
        fl_if.Grabbed_regs = 1'b1;
        repeat (32) tick();
        fl_if.Grabbed_regs  = 1'b0;
        fl_if.Release_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            fl_if.Release_reg = 6'(32 + i);
            tick();
        end
        check("full_count", 32'(fl_if.Free_count),   32);
        check("full_ovf",   32'(fl_if.Overflow_err), 0);
        fl_if.Release_reg = 6'd5;
        tick();
        fl_if.Release_valid = 1'b0;
        check("ovf_set",   32'(fl_if.Overflow_err), 1);
        check("ovf_count", 32'(fl_if.Free_count),   32);

        // Wrap: bring the tail to 63, then grab + release(40) in the same cycle.
        do_reset();
        fl_if.Grabbed_regs = 1'b1;
        repeat (32) tick();
        fl_if.Grabbed_regs  = 1'b0;
        fl_if.Release_valid = 1'b1;
        fl_if.Commit_alloc  = 1'b1;
        for (int v = 32; v < 64; v++) begin
            if (v != 40) begin
                fl_if.Release_reg = 6'(v);
                tick();
            end
        end
        fl_if.Commit_alloc = 1'b0;
        check("pre_wrap_count", 32'(fl_if.Free_count), 31);
        fl_if.Grabbed_regs = 1'b1;
        fl_if.Release_reg  = 6'd40;
        tick();
        fl_if.Grabbed_regs = 1'b0;
        check("wrap_count", 32'(fl_if.Free_count), 31);
        fl_if.Release_reg = 6'd32;
        tick();
        fl_if.Release_valid = 1'b0;
        check("post_wrap_count", 32'(fl_if.Free_count), 32);
        // ring[33..62] = 33..39, 41..63; ring[63] = 40; ring[0] = 32.
        fl_if.Grabbed_regs = 1'b1;
        for (int k = 0; k < 30; k++) begin
            check("wrap_walk", 32'(fl_if.Free_phys_reg), (k < 7) ? 32'(33 + k) : 32'(34 + k));
            tick();
        end
        check("ring63", 32'(fl_if.Free_phys_reg), 40);
        tick();
        fl_if.Grabbed_regs = 1'b0;
        check("ring0_after_wrap", 32'(fl_if.Free_phys_reg), 32);

`ifdef FREELIST_DUPCHECK_EN
        // 45 is free after reset, so releasing it again must be dropped.
        do_reset();
        fl_if.Release_valid = 1'b1;
        fl_if.Release_reg   = 6'd45;
        tick();
        fl_if.Release_valid = 1'b0;
        check("dup_set",   32'(fl_if.Dup_release_err), 1);
        check("dup_count", 32'(fl_if.Free_count),      32);
        check("dup_ovf",   32'(fl_if.Overflow_err),    0);
`else
        check("dup_tied", 32'(fl_if.Dup_release_err), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_phys_free_list
